// File: rtl/fir_ctrl_if.sv
// Handshake and datapath-control bundle between the FIR sequencer and its delay bank / MAC.
// master = sequencer side, slave = datapath / host side.
interface fir_ctrl_if #(parameter int AW = 3);
  logic          clr_in;
  logic          in_valid_in;
  logic          in_ready_out;
  logic          dwe_out;
  logic          clr_out;
  logic [AW-1:0] faddr_out;
  logic          mac_en_out;
  logic          mac_first_out;
  logic          out_valid_out;
  logic          out_ready_in;

  modport master (
    input  clr_in, in_valid_in, out_ready_in,
    output in_ready_out, dwe_out, clr_out, faddr_out,
           mac_en_out, mac_first_out, out_valid_out
  );

  modport slave (
    output clr_in, in_valid_in, out_ready_in,
    input  in_ready_out, dwe_out, clr_out, faddr_out,
           mac_en_out, mac_first_out, out_valid_out
  );
endinterface

// File: rtl/fir_ctrl.sv
// FIR tap sequencer: accepts one sample, walks all taps through the MAC, holds the result.
// Build macro FIR_CTRL_PIPE_EN inserts a WAIT state to drain a registered multiplier.
package fir_filter_pkg;
  localparam int NTAPS     = 8;
  localparam int FADDRBITS = 3;
endpackage

// state | meaning
// IDLE  | ready for a sample; bank shifts on the accepting edge
// RUN   | one tap per cycle through the MAC, faddr 0..NTAPS-1
// WAIT  | multiplier drain cycle (FIR_CTRL_PIPE_EN only)
// OUT   | accumulator result valid, held until out_ready_in
module fir_ctrl
  import fir_filter_pkg::*;
(
  input logic        clk,
  input logic        rst,
  fir_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef FIR_CTRL_PIPE_EN
    WAIT,
`endif
    OUT
  } state_t;

  localparam logic [FADDRBITS-1:0] LAST_TAP = FADDRBITS'(NTAPS - 1);

  state_t               state;
  logic [FADDRBITS-1:0] faddr;
  logic                 mac_en;
  logic                 mac_first;
  logic                 out_valid;
  logic                 accept;

  assign accept = (state == IDLE) && bus.in_valid_in && !bus.clr_in && !rst;

  always_ff @(posedge clk) begin
    if (rst || bus.clr_in) begin
      state     <= IDLE;
      faddr     <= '0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RUN;
            faddr     <= '0;
            mac_en    <= 1'b1;
            mac_first <= 1'b1;
          end
        end
        RUN: begin
          mac_first <= 1'b0;
          if (faddr == LAST_TAP) begin
            faddr  <= '0;
            mac_en <= 1'b0;
`ifdef FIR_CTRL_PIPE_EN
            state     <= WAIT;
`else
            state     <= OUT;
            out_valid <= 1'b1;
`endif
          end else begin
            faddr <= faddr + 1'b1;
          end
        end
`ifdef FIR_CTRL_PIPE_EN
        WAIT: begin
          state     <= OUT;
          out_valid <= 1'b1;
        end
`endif
        OUT: begin
          if (bus.out_ready_in) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          faddr     <= '0;
          mac_en    <= 1'b0;
          mac_first <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Clear and reset act within the same cycle, so these gates sit after the registers.
  assign bus.in_ready_out  = (state == IDLE) && !bus.clr_in && !rst;
  assign bus.dwe_out       = accept;
  assign bus.clr_out       = bus.clr_in || rst;
  assign bus.faddr_out     = faddr;
  assign bus.mac_en_out    = mac_en && !bus.clr_in && !rst;
  assign bus.mac_first_out = mac_first && !bus.clr_in && !rst;
  assign bus.out_valid_out = out_valid && !rst;

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: expected output-valid cycles are queued at stimulus time and
// popped when the controller raises out_valid_out.
module tb_fir_ctrl;
  import fir_filter_pkg::*;

`ifdef FIR_CTRL_PIPE_EN
  localparam int LAT = NTAPS + 2;
`else
  localparam int LAT = NTAPS + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_ctrl_if #(.AW(FADDRBITS)) bus ();

  fir_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dwe_seen = 0;
  int exp_q[$];
  logic valid_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    if (bus.dwe_out === 1'b1) dwe_seen++;
    if (bus.out_valid_out === 1'b1 && !valid_d) begin
      if (exp_q.size() == 0) check_val("unexpected_valid", {31'b0, bus.out_valid_out}, 0);
      else                   check_val("out_latency", cyc, exp_q.pop_front());
    end
    valid_d = (bus.out_valid_out === 1'b1);
  end

  initial begin
    int k;
    rst              = 1'b1;
    bus.clr_in       = 1'b0;
    bus.in_valid_in  = 1'b0;
    bus.out_ready_in = 1'b1;

    // reset
    step();
    bus.in_valid_in = 1'b1;
    settle();
    check_val("rst_clr_out",   bus.clr_out, 1);
    check_val("rst_in_ready",  bus.in_ready_out, 0);
    check_val("rst_dwe",       bus.dwe_out, 0);
    check_val("rst_mac_en",    bus.mac_en_out, 0);
    check_val("rst_out_valid", bus.out_valid_out, 0);
    bus.in_valid_in = 1'b0;
    step();
    rst = 1'b0;
    settle();
    check_val("post_rst_in_ready", bus.in_ready_out, 1);
    check_val("post_rst_faddr",    bus.faddr_out, 0);
    check_val("post_rst_valid",    bus.out_valid_out, 0);
    check_val("post_rst_clr_out",  bus.clr_out, 0);

    // single sample
    step();
    bus.in_valid_in = 1'b1;
    settle();
    k = cyc;
    exp_q.push_back(k + LAT);
    check_val("single_dwe", bus.dwe_out, 1);
    step();
    bus.in_valid_in = 1'b0;
    settle();
    for (int i = 0; i < NTAPS; i++) begin
      check_val("run_faddr",     bus.faddr_out, i);
      check_val("run_mac_en",    bus.mac_en_out, 1);
      check_val("run_mac_first", bus.mac_first_out, (i == 0) ? 1 : 0);
      check_val("run_in_ready",  bus.in_ready_out, 0);
      step();
    end
`ifdef FIR_CTRL_PIPE_EN
    check_val("wait_mac_en", bus.mac_en_out, 0);
    check_val("wait_valid",  bus.out_valid_out, 0);
    step();
`endif
    check_val("out_valid",  bus.out_valid_out, 1);
    check_val("out_faddr",  bus.faddr_out, 0);
    check_val("out_mac_en", bus.mac_en_out, 0);
    step();
    check_val("back_idle_ready", bus.in_ready_out, 1);
    check_val("back_idle_valid", bus.out_valid_out, 0);

    // backpressure
    bus.out_ready_in = 1'b0;
    bus.in_valid_in  = 1'b1;
    settle();
    k = cyc;
    exp_q.push_back(k + LAT);
    step();
    bus.in_valid_in = 1'b0;
    steps(LAT - 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid_in = 1'b1;
      settle();
      check_val("bp_valid_held", bus.out_valid_out, 1);
      check_val("bp_in_ready",   bus.in_ready_out, 0);
      check_val("bp_no_dwe",     bus.dwe_out, 0);
      step();
    end
    bus.in_valid_in  = 1'b0;
    bus.out_ready_in = 1'b1;
    settle();
    check_val("bp_release_valid", bus.out_valid_out, 1);
    step();
    check_val("bp_idle_valid", bus.out_valid_out, 0);
    check_val("bp_idle_ready", bus.in_ready_out, 1);

    // abort at faddr 4
    bus.in_valid_in = 1'b1;
    settle();
    step();
    bus.in_valid_in = 1'b0;
    steps(4);
    check_val("abort_faddr4", bus.faddr_out, 4);
    bus.clr_in = 1'b1;
    settle();
    check_val("abort_clr_out",   bus.clr_out, 1);
    check_val("abort_mac_en",    bus.mac_en_out, 0);
    check_val("abort_mac_first", bus.mac_first_out, 0);
    check_val("abort_dwe",       bus.dwe_out, 0);
    step();
    bus.clr_in = 1'b0;
    settle();
    check_val("abort_idle_ready", bus.in_ready_out, 1);
    check_val("abort_faddr0",     bus.faddr_out, 0);
    check_val("abort_mac_en_off", bus.mac_en_out, 0);
    steps(LAT + 2);
    check_val("abort_no_valid", bus.out_valid_out, 0);

    // collision: clear wins over a sample, then in_valid held through RUN
    bus.in_valid_in = 1'b1;
    bus.clr_in      = 1'b1;
    settle();
    check_val("coll_dwe",      bus.dwe_out, 0);
    check_val("coll_clr_out",  bus.clr_out, 1);
    check_val("coll_in_ready", bus.in_ready_out, 0);
    step();
    bus.clr_in = 1'b0;
    settle();
    check_val("coll_still_idle", bus.in_ready_out, 1);
    check_val("coll_accept_dwe", bus.dwe_out, 1);
    k = cyc;
    exp_q.push_back(k + LAT);
    step();
    for (int i = 0; i < LAT - 1; i++) begin
      check_val("hold_no_dwe", bus.dwe_out, 0);
      step();
    end
    bus.in_valid_in = 1'b0;
    settle();
    check_val("hold_out_valid", bus.out_valid_out, 1);
    step();

    // back-to-back
    bus.in_valid_in = 1'b1;
    settle();
    k = cyc;
    for (int i = 0; i < 3; i++) exp_q.push_back(k + i * (LAT + 1) + LAT);
    steps(3 * (LAT + 1) - 1);
    check_val("b2b_last_valid", bus.out_valid_out, 1);
    bus.in_valid_in = 1'b0;
    steps(3);
    check_val("b2b_idle_ready", bus.in_ready_out, 1);

    // reset in mid-RUN abandons the sample
    bus.in_valid_in = 1'b1;
    settle();
    step();
    bus.in_valid_in = 1'b0;
    steps(3);
    rst = 1'b1;
    settle();
    check_val("rstrun_clr_out", bus.clr_out, 1);
    check_val("rstrun_mac_en",  bus.mac_en_out, 0);
    steps(2);
    rst = 1'b0;
    settle();
    check_val("rstrun_ready", bus.in_ready_out, 1);
    steps(LAT + 2);
    check_val("rstrun_no_valid", bus.out_valid_out, 0);

    // reset in OUT abandons the held result
    bus.out_ready_in = 1'b0;
    bus.in_valid_in  = 1'b1;
    settle();
    k = cyc;
    exp_q.push_back(k + LAT);
    step();
    bus.in_valid_in = 1'b0;
    steps(LAT + 1);
    check_val("rstout_held", bus.out_valid_out, 1);
    rst = 1'b1;
    settle();
    check_val("rstout_valid_low", bus.out_valid_out, 0);
    steps(2);
    rst = 1'b0;
    bus.out_ready_in = 1'b1;
    steps(LAT + 2);
    check_val("rstout_no_valid", bus.out_valid_out, 0);
    check_val("rstout_ready",    bus.in_ready_out, 1);

    // totals
    step();
    check_val("queue_drained", exp_q.size(), 0);
    check_val("dwe_count",     dwe_seen, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Package constant NTAPS, default 8, number of filter taps; taken from fir_filter_pkg, not a module parameter.
REQ-002 Package constant FADDRBITS, default 3, tap address width, >= clog2(NTAPS); taken from fir_filter_pkg.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 clr_in  input  1  host clear; aborts the current operation and clears the delay registers.
REQ-007 in_valid_in  input  1  new input sample present on the shared sample bus.
REQ-008 in_ready_out  output  1  block can accept a sample.
REQ-009 dwe_out  output  1  shift strobe to the delay register bank.
REQ-010 clr_out  output  1  clear strobe to the delay register bank and the accumulator.
REQ-011 faddr_out  output  FADDRBITS  tap address to the delay-register mux and the coefficient ROM.
REQ-012 mac_en_out  output  1  accumulator update enable.
REQ-013 mac_first_out  output  1  accumulator loads the product instead of adding it.
REQ-014 out_valid_out  output  1  accumulator holds a finished output sample.
REQ-015 out_ready_in  input  1  downstream consumes the output sample.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, [WAIT], OUT; WAIT exists only with FIR_CTRL_PIPE_EN.
REQ-017 IDLE: in_ready_out = !clr_in; dwe_out = in_valid_in && in_ready_out, combinational, so the bank shifts on the accepting edge.
REQ-018 On accept the FSM SHALL go IDLE->RUN with faddr_out = 0.
REQ-019 RUN: mac_en_out = 1 every cycle; mac_first_out = 1 only while faddr_out == 0; faddr_out increments by 1 per cycle.
REQ-020 RUN with faddr_out == NTAPS-1: next state OUT (or WAIT); faddr_out returns to 0 and never reaches NTAPS.
REQ-021 WAIT: one cycle; mac_en_out = 0; next state OUT.
REQ-022 OUT: out_valid_out = 1 and held until out_ready_in = 1; on that cycle the next state is IDLE.
REQ-023 Outside RUN: mac_en_out = 0, mac_first_out = 0 and faddr_out = 0; outside IDLE: in_ready_out = 0 and dwe_out = 0.
REQ-024 Latency from the accept edge to out_valid_out high SHALL be NTAPS+1 cycles (NTAPS+2 with FIR_CTRL_PIPE_EN).
REQ-025 clr_in = 1 in any state: clr_out = 1 combinationally that cycle; next state IDLE, faddr_out = 0; dwe_out and mac_en_out forced 0 that cycle.
REQ-026 clr_in together with in_valid_in in IDLE: clear wins; the sample is not accepted and dwe_out stays 0.
REQ-027 in_valid_in outside IDLE SHALL be ignored; no sample is lost silently, because in_ready_out = 0.
REQ-028 out_ready_in outside OUT SHALL have no effect.

Reset
REQ-029 While rst = 1 at a clock edge: state IDLE, faddr_out = 0.
REQ-030 Outputs while rst = 1: dwe_out = 0, clr_out = 1, mac_en_out = 0, mac_first_out = 0, out_valid_out = 0, in_ready_out = 0.
REQ-031 Reset asserted mid-RUN or in OUT SHALL abandon the sample; no out_valid_out follows.

Configuration
REQ-032 Macro FIR_CTRL_PIPE_EN defined: WAIT state inserted after RUN to drain a registered multiplier; latency NTAPS+2.
REQ-033 FIR_CTRL_PIPE_EN undefined: RUN goes directly to OUT; latency NTAPS+1; no WAIT state logic is present.

Verification
REQ-034 Reset: rst = 1 for 2 cycles, then 0 -> in_ready_out = 1, faddr_out = 0, out_valid_out = 0, clr_out = 0.
REQ-035 Single sample, NTAPS = 8, out_ready_in = 1 -> dwe_out one cycle; faddr_out 0..7 with mac_first_out on 0 only; out_valid_out 9 cycles after accept (10 with PIPE_EN).
REQ-036 Backpressure: out_ready_in = 0 for 5 cycles in OUT -> out_valid_out held 5 cycles and in_ready_out = 0 throughout; the 6th cycle with out_ready_in = 1 returns to IDLE.
REQ-037 Abort: clr_in = 1 at faddr_out = 4 -> clr_out = 1 that cycle, IDLE next cycle, no out_valid_out.
REQ-038 Collision: in_valid_in = 1 and clr_in = 1 in IDLE -> dwe_out = 0 and the state stays IDLE; in_valid_in held during RUN -> no extra dwe_out.
REQ-039 Back-to-back: 3 samples with in_valid_in held high and out_ready_in = 1 -> 3 accepts, each 1 cycle after the previous OUT, giving 3 out_valid_out pulses.
